// File: rtl/iir_coeff_loader_if.sv
// rtl/iir_coeff_loader_if.sv - host configuration word stream into the notch coefficient loader
interface iir_coeff_loader_if #(
  parameter int COEFF_WIDTH = 20
);
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic signed [COEFF_WIDTH-1:0] cfg_data;
  logic                          cfg_sel;
  logic                          cfg_abort;

  modport master (
    output cfg_valid, cfg_data, cfg_sel, cfg_abort,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_sel, cfg_abort,
    output cfg_ready
  );
endinterface

// File: rtl/iir_coeff_loader.sv
// rtl/iir_coeff_loader.sv - assembles 5-word notch coefficient sets and commits them between samples
// Optional readback check after each commit: IIR_COEFF_VERIFY_EN.
module iir_coeff_loader #(
  parameter int  COEFF_WIDTH = 20,
  parameter int  GAP_TIMEOUT = 16,
  localparam int COEFF_DEPTH = 5
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     valid_in,
  iir_coeff_loader_if.slave                        cfg,
  output logic                                     coeff_wr_en_1MHz,
  output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]  coeff_out_1MHz,
  output logic                                     coeff_wr_en_2_4MHz,
  output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]  coeff_out_2_4MHz,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     sel_err,
  output logic                                     forced
`ifdef IIR_COEFF_VERIFY_EN
  ,
  input  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]  coeff_rb_1MHz,
  input  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]  coeff_rb_2_4MHz,
  output logic                                     verify_err
`endif
);

  localparam int         GAP_W    = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
  localparam logic [2:0] LAST_IDX = 3'(COEFF_DEPTH - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_GAP, COMMIT
`ifdef IIR_COEFF_VERIFY_EN
    , VERIFY
`endif
  } state_t;

  state_t state, state_d;

  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] stage;
  logic [2:0]       idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             sel_q;

  logic store, idx_clr, gap_clr, gap_inc, commit_go, timeout_go, sel_mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d            = state;
    cfg.cfg_ready      = 1'b0;
    store              = 1'b0;
    idx_clr            = 1'b0;
    gap_clr            = 1'b0;
    gap_inc            = 1'b0;
    commit_go          = 1'b0;
    timeout_go         = 1'b0;
    sel_mismatch       = 1'b0;
    busy               = 1'b1;
    done               = 1'b0;
    coeff_wr_en_1MHz   = 1'b0;
    coeff_wr_en_2_4MHz = 1'b0;
    case (state)
      IDLE: begin
        busy          = 1'b0;
        cfg.cfg_ready = 1'b1;
        if (cfg.cfg_valid) begin
          store   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cfg.cfg_ready = 1'b1;
        // Abort wins over a word offered in the same cycle.
        if (cfg.cfg_abort) begin
          idx_clr = 1'b1;
          state_d = IDLE;
        end else if (cfg.cfg_valid) begin
          if (cfg.cfg_sel != sel_q) begin
            sel_mismatch = 1'b1;
            idx_clr      = 1'b1;
            state_d      = IDLE;
          end else begin
            store = 1'b1;
            if (idx == LAST_IDX) begin
              gap_clr = 1'b1;
              state_d = WAIT_GAP;
            end
          end
        end
      end
      WAIT_GAP: begin
        if (cfg.cfg_abort) begin
          idx_clr = 1'b1;
          state_d = IDLE;
        end else if (!valid_in) begin
          commit_go = 1'b1;
          state_d   = COMMIT;
        end else if (gap_cnt == GAP_MAX) begin
          commit_go  = 1'b1;
          timeout_go = 1'b1;
          state_d    = COMMIT;
        end else begin
          gap_inc = 1'b1;
        end
      end
      COMMIT: begin
        done               = 1'b1;
        coeff_wr_en_1MHz   = ~sel_q;
        coeff_wr_en_2_4MHz = sel_q;
`ifdef IIR_COEFF_VERIFY_EN
        state_d = VERIFY;
`else
        state_d = IDLE;
`endif
      end
`ifdef IIR_COEFF_VERIFY_EN
      VERIFY: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage            <= '0;
      idx              <= '0;
      gap_cnt          <= '0;
      sel_q            <= 1'b0;
      coeff_out_1MHz   <= '0;
      coeff_out_2_4MHz <= '0;
      forced           <= 1'b0;
      sel_err          <= 1'b0;
    end else begin
      forced  <= timeout_go;
      sel_err <= sel_mismatch;
      if (store) begin
        if (state == IDLE) begin
          stage[0] <= cfg.cfg_data;
          sel_q    <= cfg.cfg_sel;
          idx      <= 3'd1;
        end else begin
          stage[idx] <= cfg.cfg_data;
          idx        <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
        end
      end else if (idx_clr) begin
        idx <= '0;
      end
      if (gap_clr)      gap_cnt <= '0;
      else if (gap_inc) gap_cnt <= gap_cnt + 1'b1;
      // Target array updates on the edge into COMMIT so wr_en sees the new set.
      if (commit_go) begin
        if (sel_q) coeff_out_2_4MHz <= stage;
        else       coeff_out_1MHz   <= stage;
      end
    end
  end

`ifdef IIR_COEFF_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      verify_err <= 1'b0;
    end else if (commit_go) begin
      verify_err <= 1'b0;
    end else if (state == VERIFY) begin
      if ((sel_q ? coeff_rb_2_4MHz : coeff_rb_1MHz) != stage) verify_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iir_coeff_loader.sv
// tb/tb_iir_coeff_loader.sv - randomized scoreboard bench for iir_coeff_loader
module tb_iir_coeff_loader;
  localparam int W  = 20;
  localparam int D  = 5;
  localparam int GT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic wr1, wr2, busy, done, sel_err, forced;
  logic [D-1:0][W-1:0] out1, out2;

  iir_coeff_loader_if #(.COEFF_WIDTH(W)) cfg();

`ifdef IIR_COEFF_VERIFY_EN
  logic [D-1:0][W-1:0] rb1, rb2;
  logic verify_err;
  logic corrupt = 1'b0;
`endif

  always #5 clk = ~clk;

  iir_coeff_loader #(.COEFF_WIDTH(W), .GAP_TIMEOUT(GT)) dut (
    .clk                (clk),
    .rst                (rst),
    .valid_in           (valid_in),
    .cfg                (cfg),
    .coeff_wr_en_1MHz   (wr1),
    .coeff_out_1MHz     (out1),
    .coeff_wr_en_2_4MHz (wr2),
    .coeff_out_2_4MHz   (out2),
    .busy               (busy),
    .done               (done),
    .sel_err            (sel_err),
    .forced             (forced)
`ifdef IIR_COEFF_VERIFY_EN
    ,
    .coeff_rb_1MHz      (rb1),
    .coeff_rb_2_4MHz    (rb2),
    .verify_err         (verify_err)
`endif
  );

  typedef struct {
    logic                sel;
    logic [D-1:0][W-1:0] words;
    logic                frc;
    int                  cyc;
  } exp_t;

  exp_t expq[$];
  int   selq[$];
  exp_t mon_e;
  logic [D-1:0][W-1:0] mdl [2];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

`ifdef IIR_COEFF_VERIFY_EN
  // Filters echo back what they were last written; corrupt flips word 3.
  always_comb begin
    rb1 = mdl[0];
    rb2 = mdl[1];
    if (corrupt) begin
      rb1[3] = ~rb1[3];
      rb2[3] = ~rb2[3];
    end
  end
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr1 || wr2) begin
        chk("wr_en exclusive", 128'(wr1 && wr2), 128'(0));
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected commit: got wr1=%0b wr2=%0b expected none", wr1, wr2);
        end else begin
          mon_e = expq.pop_front();
          mdl[mon_e.sel] = mon_e.words;
          chk("commit target", 128'(wr2), 128'(mon_e.sel));
          chk("commit cycle", 128'(cyc), 128'(mon_e.cyc));
          chk("forced", 128'(forced), 128'(mon_e.frc));
          chk("done", 128'(done), 128'(1));
          chk("coeff_out_1MHz", 128'(out1), 128'(mdl[0]));
          chk("coeff_out_2_4MHz", 128'(out2), 128'(mdl[1]));
        end
      end else if (done || forced) begin
        chk("stray done/forced", 128'({done, forced}), 128'(0));
      end
      if (sel_err) begin
        if (selq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected sel_err: got 1 expected 0");
        end else begin
          chk("sel_err cycle", 128'(cyc), 128'(selq.pop_front()));
        end
        chk("busy at sel_err", 128'(busy), 128'(0));
      end
    end
  end

  task automatic send(input logic sel, input logic [W-1:0] d, input bit exp_selerr);
    int g;
    g = 0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_sel   = sel;
    cfg.cfg_data  = d;
    while (!cfg.cfg_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!cfg.cfg_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL cfg_ready wait: got 0 expected 1 within 50 cycles");
    end
    if (exp_selerr) selq.push_back(cyc + 1);
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
  endtask

  // valid_in stays high for n cycles after the 5th transfer, then drops.
  task automatic run_set(input logic sel, input logic [D-1:0][W-1:0] w, input int n);
    exp_t e;
    int m;
    for (int i = 0; i < D; i++) send(sel, w[i], 1'b0);
    m = (n < GT - 1) ? n : GT - 1;
    e.sel   = sel;
    e.words = w;
    e.frc   = (n >= GT);
    e.cyc   = cyc + m + 1;
    expq.push_back(e);
    for (int k = 0; k <= m; k++) begin
      valid_in = (k < n);
      @(negedge clk);
    end
    valid_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_words(output logic [D-1:0][W-1:0] w);
    for (int i = 0; i < D; i++) w[i] = W'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_abort = 1'b0;
    valid_in = 1'b0;
    mdl[0] = '0;
    mdl[1] = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset cfg_ready", 128'(cfg.cfg_ready), 128'(1));
    chk("reset coeff_out_1MHz", 128'(out1), 128'(0));
    chk("reset coeff_out_2_4MHz", 128'(out2), 128'(0));
    chk("reset pulses", 128'({wr1, wr2, done, sel_err, forced}), 128'(0));
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [D-1:0][W-1:0] w, tp;
    int g;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_abort = 1'b0;
    cfg.cfg_sel   = 1'b0;
    cfg.cfg_data  = '0;
    mdl[0] = '0;
    mdl[1] = '0;
    do_reset();

    tp[0] = 20'h40000; tp[1] = 20'h00100; tp[2] = 20'h40000;
    tp[3] = 20'hFFF00; tp[4] = 20'h3C000;
    run_set(1'b1, tp, 0);
    run_set(1'b0, tp, 5);
    run_set(1'b0, tp, 40);
    rand_words(w); run_set(1'b1, w, GT - 1);
    rand_words(w); run_set(1'b0, w, GT);

    // Select change mid-set
    for (int i = 0; i < 3; i++) send(1'b0, W'($urandom), 1'b0);
    send(1'b1, W'($urandom), 1'b1);
    @(negedge clk);
    rand_words(w); run_set(1'b0, w, 0);

    // Abort in LOAD, possibly with a word in the same cycle
    for (int i = 0; i < 2; i++) send(1'b1, W'($urandom), 1'b0);
    cfg.cfg_abort = 1'b1;
    cfg.cfg_valid = 1'($urandom_range(0, 1));
    cfg.cfg_data  = W'($urandom);
    @(negedge clk);
    cfg.cfg_abort = 1'b0;
    cfg.cfg_valid = 1'b0;
    chk("busy after abort", 128'(busy), 128'(0));

    // Reset in the middle of the next set
    for (int i = 0; i < 3; i++) send(1'b1, W'($urandom), 1'b0);
    do_reset();
    rand_words(w); run_set(1'b1, w, 2);

    // Abort while waiting for a sample gap
    valid_in = 1'b1;
    for (int i = 0; i < D; i++) send(1'b0, W'($urandom), 1'b0);
    repeat ($urandom_range(1, 10)) @(negedge clk);
    cfg.cfg_abort = 1'b1;
    @(negedge clk);
    cfg.cfg_abort = 1'b0;
    valid_in = 1'b0;
    chk("busy after gap abort", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);

    for (int s = 0; s < 25; s++) begin
      rand_words(w);
      run_set(1'($urandom), w, ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 22)));
    end

`ifdef IIR_COEFF_VERIFY_EN
    corrupt = 1'b1;
    rand_words(w); run_set(1'b0, w, 0);
    @(negedge clk);
    chk("verify_err on bad readback", 128'(verify_err), 128'(1));
    corrupt = 1'b0;
    rand_words(w); run_set(1'b1, w, 0);
    @(negedge clk);
    chk("verify_err cleared by good set", 128'(verify_err), 128'(0));
`endif

    g = 0;
    while ((expq.size() != 0 || selq.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("pending commits", 128'(expq.size()), 128'(0));
    chk("pending sel_err", 128'(selq.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
